// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with selectable width and modulus,
// parallel load, wrap or saturate at the range ends, a combinational terminal-count output
// for cascading, and a registered one-cycle rollover pulse.
//
// Optional feature: define COUNTER_CMP_EN to add cmp_value/cmp_match, a registered compare
// that is high in the same cycle q equals cmp_value.

module param_updown_counter #(
    parameter int unsigned     WIDTH    = 16,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             clearN,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             rollover
`ifdef COUNTER_CMP_EN
    ,
    input  logic [WIDTH-1:0] cmp_value,
    output logic             cmp_match
`endif
);

    // Highest legal count; q never leaves 0..max_val.
    localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULO - 64'd1);
    localparam logic [WIDTH-1:0] one     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             rollover_q, rollover_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == max_val);
    assign at_zero = (count_q == '0);

    // Next count and wrap detection; priority is load, then enable, then hold.
    always_comb begin
        count_d    = count_q;
        rollover_d = 1'b0;
        if (load) begin
            // Out-of-range load values clamp to the top of the range.
            count_d = (load_value > max_val) ? max_val : load_value;
        end else if (enable) begin
            if (up) begin
                if (!at_max) begin
                    count_d = count_q + one;
                end else if (!SATURATE) begin
                    count_d    = '0;
                    rollover_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - one;
                end else if (!SATURATE) begin
                    count_d    = max_val;
                    rollover_d = 1'b1;
                end
            end
        end
    end

    // Count and rollover state, cleared asynchronously.
    always_ff @(posedge clock or negedge clearN) begin
        if (!clearN) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    // Terminal count is zero-latency so a following stage can count on this same edge.
    always_comb begin
        tc = enable & (up ? at_max : at_zero);
    end

    assign q        = count_q;
    assign rollover = rollover_q;

`ifdef COUNTER_CMP_EN
    logic cmp_match_q;
    logic cmp_hit;

    // Compare against the next count so the match lines up with q; values past the
    // range can never equal a legal count.
    assign cmp_hit = (cmp_value <= max_val) && (count_d == cmp_value);

    // Registered compare flag.
    always_ff @(posedge clock or negedge clearN) begin
        if (!clearN) begin
            cmp_match_q <= 1'b0;
        end else begin
            cmp_match_q <= cmp_hit;
        end
    end

    assign cmp_match = cmp_match_q;
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: four configurations share one set of controls and are
// checked against an arithmetic reference model, a vector table and directed sequences.
`timescale 1ns/1ps

module tb_param_updown_counter;

    logic        clock;
    logic        clearN;
    logic        enable;
    logic        up;
    logic        load;
    logic [15:0] load_value;

    logic [15:0] q_def;
    logic [3:0]  q_wrap, q_sat;
    logic [1:0]  q_m2;
    logic        tc_def, tc_wrap, tc_sat, tc_m2;
    logic        ro_def, ro_wrap, ro_sat, ro_m2;
`ifdef COUNTER_CMP_EN
    logic [15:0] cmp_value;
    logic        cm_def, cm_wrap, cm_sat, cm_m2;
`endif

    int checks = 0;
    int errors = 0;

    // Configuration table: index 0 default, 1 mod-10 wrap, 2 mod-10 saturate, 3 mod-2 wrap.
    int unsigned mod_m [4] = '{65536, 10, 10, 2};
    int unsigned wid   [4] = '{16, 4, 4, 2};
    bit          sat   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    int unsigned mq  [4];
    bit          mro [4];
    bit          mcm [4];

    logic [15:0] dq [4];
    logic [3:0]  dtc, dro;
`ifdef COUNTER_CMP_EN
    logic [3:0]  dcm;
`endif

    param_updown_counter #(.WIDTH(16)) u_def (
        .clock(clock), .clearN(clearN), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .q(q_def), .tc(tc_def), .rollover(ro_def)
`ifdef COUNTER_CMP_EN
        , .cmp_value(cmp_value), .cmp_match(cm_def)
`endif
    );

    param_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_wrap (
        .clock(clock), .clearN(clearN), .enable(enable), .up(up), .load(load),
        .load_value(load_value[3:0]), .q(q_wrap), .tc(tc_wrap), .rollover(ro_wrap)
`ifdef COUNTER_CMP_EN
        , .cmp_value(cmp_value[3:0]), .cmp_match(cm_wrap)
`endif
    );

    param_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_sat (
        .clock(clock), .clearN(clearN), .enable(enable), .up(up), .load(load),
        .load_value(load_value[3:0]), .q(q_sat), .tc(tc_sat), .rollover(ro_sat)
`ifdef COUNTER_CMP_EN
        , .cmp_value(cmp_value[3:0]), .cmp_match(cm_sat)
`endif
    );

    param_updown_counter #(.WIDTH(2), .MODULO(2), .SATURATE(1'b0)) u_m2 (
        .clock(clock), .clearN(clearN), .enable(enable), .up(up), .load(load),
        .load_value(load_value[1:0]), .q(q_m2), .tc(tc_m2), .rollover(ro_m2)
`ifdef COUNTER_CMP_EN
        , .cmp_value(cmp_value[1:0]), .cmp_match(cm_m2)
`endif
    );

    assign dq[0] = q_def;
    assign dq[1] = {12'd0, q_wrap};
    assign dq[2] = {12'd0, q_sat};
    assign dq[3] = {14'd0, q_m2};
    assign dtc   = {tc_m2, tc_sat, tc_wrap, tc_def};
    assign dro   = {ro_m2, ro_sat, ro_wrap, ro_def};
`ifdef COUNTER_CMP_EN
    assign dcm   = {cm_m2, cm_sat, cm_wrap, cm_def};
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mq[k]  = 0;
            mro[k] = 1'b0;
            mcm[k] = 1'b0;
        end
    endtask

    // Reference behaviour for one rising edge, from plain modular arithmetic.
    task automatic model_edge();
        int unsigned lv, nq, msk;
        bit          at_end;
        if (!clearN) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 4; k++) begin
            msk = (wid[k] == 16) ? 32'hFFFF : ((32'd1 << wid[k]) - 1);
            lv  = load_value & msk;
            if (load) begin
                nq     = (lv < mod_m[k]) ? lv : mod_m[k] - 1;
                mro[k] = 1'b0;
            end else if (enable) begin
                at_end = up ? (mq[k] == mod_m[k] - 1) : (mq[k] == 0);
                if (at_end && sat[k]) begin
                    nq     = mq[k];
                    mro[k] = 1'b0;
                end else begin
                    nq     = (mq[k] + (up ? 1 : mod_m[k] - 1)) % mod_m[k];
                    mro[k] = at_end;
                end
            end else begin
                nq     = mq[k];
                mro[k] = 1'b0;
            end
            mq[k] = nq;
`ifdef COUNTER_CMP_EN
            mcm[k] = (nq == (cmp_value & msk));
`endif
        end
    endtask

    task automatic check_all();
        bit exp_tc;
        for (int k = 0; k < 4; k++) begin
            exp_tc = enable && (up ? (mq[k] == mod_m[k] - 1) : (mq[k] == 0));
            check($sformatf("model_q[%0d]", k), dq[k], mq[k]);
            check($sformatf("model_rollover[%0d]", k), dro[k], mro[k]);
            check($sformatf("model_tc[%0d]", k), dtc[k], exp_tc);
`ifdef COUNTER_CMP_EN
            check($sformatf("model_cmp[%0d]", k), dcm[k], mcm[k]);
`endif
        end
    endtask

    // Drive controls at the falling edge, advance one rising edge, sample 1ns later.
    task automatic apply(input bit ld, input bit en, input bit u, input logic [15:0] lv);
        @(negedge clock);
        load       = ld;
        enable     = en;
        up         = u;
        load_value = lv;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    // Assert clearN between edges, check the immediate clear, release before the next edge.
    task automatic mid_clear();
        @(negedge clock);
        #2;
        clearN = 1'b0;
        model_reset();
        #1;
        check("async_clear_q", q_def, 0);
        check("async_clear_rollover", ro_def, 0);
        check_all();
        #1;
        clearN = 1'b1;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        bit          ld;
        bit          en;
        bit          u;
        logic [15:0] lv;
        int unsigned eq_def;
        int unsigned eq_wrap;
        int unsigned eq_sat;
        bit          ero_wrap;
    } vec_t;

    vec_t vecs [12];
    bit   seen_ro;

    initial begin
        // Table starts from q=0 in every configuration.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'd0,  65535, 9, 0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'd0,  0,     0, 1, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'd0,  1,     1, 2, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'd0,  1,     1, 2, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'd8,  8,     8, 8, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'd0,  9,     9, 9, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'd0,  10,    0, 9, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'd15, 15,    9, 9, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'd0,  14,    8, 8, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 16'd0,  0,     0, 0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd0,  65535, 9, 0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 16'd0,  65535, 9, 0, 1'b0};

        clearN     = 1'b1;
        enable     = 1'b0;
        up         = 1'b0;
        load       = 1'b0;
        load_value = '0;
`ifdef COUNTER_CMP_EN
        cmp_value  = 16'd7;
`endif
        model_reset();
        #2;
        clearN = 1'b0;
        #1;
        check_all();

        // Held in reset across three edges with counting requested.
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, 16'd0);
            check("reset_q", q_def, 0);
            check("reset_rollover", ro_def, 0);
            check("reset_tc", tc_def, 0);
        end
        clearN = 1'b1;

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].ld, vecs[i].en, vecs[i].u, vecs[i].lv);
            check($sformatf("vec%0d_q_def", i), q_def, vecs[i].eq_def);
            check($sformatf("vec%0d_q_wrap", i), q_wrap, vecs[i].eq_wrap);
            check($sformatf("vec%0d_q_sat", i), q_sat, vecs[i].eq_sat);
            check($sformatf("vec%0d_ro_wrap", i), ro_wrap, vecs[i].ero_wrap);
        end

        // Mod-10 wrap counting down from 0: wraps to 9, ten more edges come back to 9.
        mid_clear();
        apply(1'b0, 1'b1, 1'b0, 16'd0);
        check("down_wrap_q", q_wrap, 9);
        check("down_wrap_ro", ro_wrap, 1);
        apply(1'b0, 1'b1, 1'b0, 16'd0);
        check("down_wrap_ro_once", ro_wrap, 0);
        for (int i = 0; i < 9; i++) apply(1'b0, 1'b1, 1'b0, 16'd0);
        check("down_wrap_again_q", q_wrap, 9);
        check("down_wrap_again_ro", ro_wrap, 1);

        // Mod-10 saturate: sticks at 9 going up and at 0 going down.
        apply(1'b1, 1'b0, 1'b0, 16'd0);
        seen_ro = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 1'b1, 1'b1, 16'd0);
            seen_ro = seen_ro | ro_sat;
        end
        check("sat_up_q", q_sat, 9);
        check("sat_up_tc", tc_sat, 1);
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, 1'b1, 1'b0, 16'd0);
            seen_ro = seen_ro | ro_sat;
        end
        check("sat_down_q", q_sat, 0);
        check("sat_never_rollover", seen_ro, 0);

        // Mod-2 with alternating direction wraps on every edge.
        apply(1'b1, 1'b0, 1'b0, 16'd1);
        apply(1'b0, 1'b1, 1'b1, 16'd0);
        check("m2_ro_a", ro_m2, 1);
        apply(1'b0, 1'b1, 1'b0, 16'd0);
        check("m2_ro_b", ro_m2, 1);
        check("m2_q_b", q_m2, 1);
        apply(1'b0, 1'b1, 1'b1, 16'd0);
        check("m2_ro_c", ro_m2, 1);

        // Load beats enable; loads past the range clamp; hold keeps the value.
        apply(1'b1, 1'b0, 1'b0, 16'd5);
        apply(1'b1, 1'b1, 1'b1, 16'd3);
        check("prio_q_wrap", q_wrap, 3);
        check("prio_q_def", q_def, 3);
        apply(1'b1, 1'b1, 1'b1, 16'd12);
        check("clamp_q_wrap", q_wrap, 9);
        check("clamp_q_def", q_def, 12);
        for (int i = 0; i < 4; i++) apply(1'b0, 1'b0, 1'(i), 16'($urandom));
        check("hold_q_wrap", q_wrap, 9);

        // Full default-width sweep from 0.
        mid_clear();
        for (int i = 1; i <= 65536; i++) begin
            apply(1'b0, 1'b1, 1'b1, 16'd0);
            if (i % 4096 == 0 || i >= 65535) check("sweep_q", q_def, i % 65536);
            if (i == 65535) check("sweep_tc_top", tc_def, 1);
            if (i == 65536) check("sweep_rollover", ro_def, 1);
        end
        apply(1'b0, 1'b1, 1'b1, 16'd0);
        check("sweep_rollover_once", ro_def, 0);
        check("sweep_q_after", q_def, 1);

        // Count to 0x00A5 then clear asynchronously mid-cycle.
        apply(1'b1, 1'b0, 1'b1, 16'h00A0);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b1, 16'd0);
        check("count_a5", q_def, 16'h00A5);
        mid_clear();

`ifdef COUNTER_CMP_EN
        cmp_value = 16'd7;
        apply(1'b1, 1'b0, 1'b1, 16'd0);
        for (int i = 1; i <= 9; i++) begin
            apply(1'b0, 1'b1, 1'b1, 16'd0);
            check("cmp_match_count", cm_def, (i == 7) ? 1 : 0);
        end
        apply(1'b1, 1'b0, 1'b0, 16'd7);
        check("cmp_match_load", cm_def, 1);
        check("cmp_m2_never", cm_m2, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] lv;
            lv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
`ifdef COUNTER_CMP_EN
            if ($urandom_range(0, 31) == 0) cmp_value = 16'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 63) == 0) begin
                mid_clear();
            end else begin
                apply($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      1'($urandom_range(0, 1)), lv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
